// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command path: frame parser state encoding,
// header tag default and ALU function codes.
package alu_cmd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGetA  = 2'd1,
    StGetB  = 2'd2,
    StIssue = 2'd3
  } frame_state_e;

  localparam logic [3:0] CMD_TAG_DEF = 4'hA;
  // Highest function code the ALU implements.
  localparam logic [3:0] FUN_MAX     = 4'b1110;

  localparam logic [3:0] FUN_ADD     = 4'd0;
  localparam logic [3:0] FUN_SFTL    = 4'd14;

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-byte gap counter: counts while enabled, flags timeout at TIMEOUT_CYC-1.
module frame_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CntW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CntLast)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout = enable && (cnt_q == CntLast);

endmodule

// File: rtl/alu_cmd_frame_parser.sv
// Assembles {tag,fun}/OpA/OpB byte frames into an ALU command and strobes Enable.
// Build option ALU_CMD_FUN_CHECK_EN rejects headers whose function code exceeds FUN_MAX.
module alu_cmd_frame_parser
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ALU_OP      = 4,
  parameter logic [DATA_W-ALU_OP-1:0] CMD_TAG = (DATA_W - ALU_OP)'(CMD_TAG_DEF),
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] RxData,
  input  logic              RxValid,
  input  logic              RxParErr,
  input  logic              DstReady,
  output logic [ALU_OP-1:0] AluFun,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic              Enable,
  output logic              FrameErr,
  output logic              Busy
);

  frame_state_e      state_q, state_d;
  logic [ALU_OP-1:0] fun_q, fun_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              frame_err_q, frame_err_d;
  logic              accept;
  logic              in_get;
  logic              timeout;
  logic              tag_ok;
  logic              fun_ok;

  assign tag_ok = (RxData[DATA_W-1:ALU_OP] == CMD_TAG);
`ifdef ALU_CMD_FUN_CHECK_EN
  assign fun_ok = (RxData[ALU_OP-1:0] <= ALU_OP'(FUN_MAX));
`else
  assign fun_ok = 1'b1;
`endif

  assign in_get = (state_q == StGetA) || (state_q == StGetB);

  // Cleared outside the operand states so it always starts from zero on entry.
  frame_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .clear  (accept || !in_get),
    .enable (in_get),
    .timeout(timeout)
  );

  always_comb begin
    state_d     = state_q;
    fun_d       = fun_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    frame_err_d = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (RxValid) begin
          if (!RxParErr && tag_ok && fun_ok) begin
            fun_d   = RxData[ALU_OP-1:0];
            accept  = 1'b1;
            state_d = StGetA;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      StGetA, StGetB: begin
        // A byte arriving on the timeout cycle takes precedence.
        if (RxValid) begin
          if (RxParErr) begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end else if (state_q == StGetA) begin
            op_a_d  = RxData;
            accept  = 1'b1;
            state_d = StGetB;
          end else begin
            op_b_d  = RxData;
            accept  = 1'b1;
            state_d = StIssue;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StIssue: begin
        // Overrun byte is dropped; the pending command still goes out.
        if (RxValid) begin
          frame_err_d = 1'b1;
        end
        if (DstReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      fun_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fun_q       <= fun_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign AluFun   = fun_q;
  assign OpA      = op_a_q;
  assign OpB      = op_b_q;
  assign FrameErr = frame_err_q;
  assign Enable   = (state_q == StIssue) && DstReady;
  assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_frame_parser.sv
// Scoreboard bench: a frame-level model queues per-cycle expectations, a monitor checks them.
module tb_alu_cmd_frame_parser;

  localparam int TIMEOUT = 1024;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxParErr;
  logic       DstReady;
  logic [3:0] AluFun;
  logic [7:0] OpA;
  logic [7:0] OpB;
  logic       Enable;
  logic       FrameErr;
  logic       Busy;

  always #5 Clk = ~Clk;

  alu_cmd_frame_parser dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .RxData  (RxData),
    .RxValid (RxValid),
    .RxParErr(RxParErr),
    .DstReady(DstReady),
    .AluFun  (AluFun),
    .OpA     (OpA),
    .OpB     (OpB),
    .Enable  (Enable),
    .FrameErr(FrameErr),
    .Busy    (Busy)
  );

  typedef struct {
    bit         busy;
    bit         en;
    bit         err;
    logic [3:0] fun;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   en_seen = 0;

  // Reference model: bytes collected so far in the current frame, a pending command,
  // idle cycles since the last accepted byte, and the last latched command fields.
  logic [7:0] frame[$];
  bit         pending  = 0;
  int         gap      = 0;
  bit         err_pend = 0;
  logic [3:0] m_fun    = '0;
  logic [7:0] m_a      = '0;
  logic [7:0] m_b      = '0;

  function automatic bit header_ok(input logic [7:0] d);
    bit ok;
    ok = (d[7:4] == 4'hA);
`ifdef ALU_CMD_FUN_CHECK_EN
    ok = ok && (d[3:0] <= 4'd14);
`endif
    return ok;
  endfunction

  task automatic model_step(input bit v, input logic [7:0] d, input bit pe, input bit rdy,
                            input bit rst);
    exp_t e;
    e.busy = (frame.size() > 0) || pending;
    e.en   = pending && rdy;
    e.err  = err_pend;
    e.fun  = m_fun;
    e.a    = m_a;
    e.b    = m_b;
    exp_q.push_back(e);
    err_pend = 0;
    if (!rst) begin
      frame.delete();
      pending = 0;
      gap     = 0;
      m_fun   = '0;
      m_a     = '0;
      m_b     = '0;
    end else if (pending) begin
      if (v) err_pend = 1;
      if (rdy) pending = 0;
    end else if (frame.size() == 0) begin
      if (v) begin
        if (!pe && header_ok(d)) begin
          frame.push_back(d);
          m_fun = d[3:0];
          gap   = 0;
        end else begin
          err_pend = 1;
        end
      end
    end else begin
      if (v) begin
        if (pe) begin
          frame.delete();
          err_pend = 1;
        end else begin
          if (frame.size() == 1) m_a = d;
          else m_b = d;
          frame.push_back(d);
          gap = 0;
          if (frame.size() == 3) begin
            frame.delete();
            pending = 1;
          end
        end
      end else if (gap == TIMEOUT - 1) begin
        frame.delete();
        err_pend = 1;
      end else begin
        gap++;
      end
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit pe, input bit rdy,
                      input bit rst);
    RxValid  = v;
    RxData   = d;
    RxParErr = pe;
    DstReady = rdy;
    Reset_n  = rst;
    model_step(v, d, pe, rdy, rst);
    @(posedge Clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0, rdy, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    tick(1'b1, d, 1'b0, rdy, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busy", 32'(Busy), 32'(e.busy));
        check("enable", 32'(Enable), 32'(e.en));
        check("frame_err", 32'(FrameErr), 32'(e.err));
        check("fun_opa_opb", 32'({AluFun, OpA, OpB}), 32'({e.fun, e.a, e.b}));
        if (Enable === 1'b1) en_seen++;
      end
    end
  end

  initial begin : driver
    RxValid  = 1'b0;
    RxData   = '0;
    RxParErr = 1'b0;
    DstReady = 1'b1;
    Reset_n  = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Basic frame, Enable one cycle after OpB.
    send(8'hA0, 1'b1); send(8'h12, 1'b1); send(8'h34, 1'b1);
    idle(3, 1'b1);

    // Bad tag, then a good frame.
    send(8'h50, 1'b1);
    idle(2, 1'b1);
    send(8'hA2, 1'b1); send(8'h05, 1'b1); send(8'h07, 1'b1);
    idle(3, 1'b1);

    // Timeout after header, then a byte landing on the last allowed cycle.
    send(8'hA1, 1'b1);
    idle(TIMEOUT + 2, 1'b1);
    send(8'hA1, 1'b1);
    idle(TIMEOUT - 1, 1'b1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(3, 1'b1);

    // Back-pressure with an overrun byte mid-wait.
    send(8'hA4, 1'b0); send(8'hF0, 1'b0); send(8'h0F, 1'b0);
    idle(10, 1'b0);
    send(8'h99, 1'b0);
    idle(9, 1'b0);
    idle(3, 1'b1);

    // Reset mid-frame, then a normal frame.
    send(8'hA3, 1'b1); send(8'h11, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    send(8'hA5, 1'b1); send(8'h21, 1'b1); send(8'h43, 1'b1);
    idle(3, 1'b1);

    // Function code above FUN_MAX.
    send(8'hAF, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1);
    idle(3, 1'b1);

    // Parity error on an operand byte.
    send(8'hA6, 1'b1);
    tick(1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 1) == 0) ? {4'hA, 4'($urandom)} : 8'($urandom);
      tick(($urandom_range(0, 9) < 4), d, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) != 0));
    end
    idle(4, 1'b1);

    repeat (2) @(negedge Clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("enable_activity", 32'(en_seen > 4), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
